// File: rtl/polar_encoder.sv
// Non-systematic polar encoder: x = u * F^{(x)n}, natural order. Serial info-bit load,
// one butterfly stage per cycle, parallel codeword out over valid/ready.
module polar_encoder #(
  parameter int unsigned    N           = 16,
  parameter int unsigned    LOG2N       = 4,
  parameter int unsigned    K           = 8,
  parameter logic [N-1:0]   FROZEN_MASK = 16'h017F
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         in_bit,
  output logic         in_ready,
  output logic         out_valid,
  output logic [N-1:0] out_codeword,
  input  logic         out_ready,
  output logic         busy
);

  localparam int unsigned CntW = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned StgW = (LOG2N > 1) ? $clog2(LOG2N) : 1;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StLoad, StEncode, StOut} state_e;

  // Index of the k-th non-frozen position, resolved at elaboration.
  function automatic int unsigned info_pos(input int unsigned k);
    int unsigned c;
    c = 0;
    info_pos = 0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!FROZEN_MASK[i]) begin
        if (c == k) info_pos = i;
        c++;
      end
    end
  endfunction

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [StgW-1:0]   stage_q;
  logic [N-1:0]      v_q;
  logic [N-1:0]      cw_q;
  logic              out_valid_q;
  logic              in_ready_q;

  logic [IdxW-1:0]           pos_tbl [K];
  logic [LOG2N-1:0][N-1:0]   stage_v;

  for (genvar g = 0; g < K; g++) begin : g_pos
    assign pos_tbl[g] = IdxW'(info_pos(g));
  end

  // All butterfly stages are wired in parallel; stage_q picks the one applied this cycle.
  for (genvar s = 0; s < LOG2N; s++) begin : g_stage
    for (genvar i = 0; i < N; i++) begin : g_bit
      if (((i >> s) & 1) == 0) begin : g_xor
        assign stage_v[s][i] = v_q[i] ^ v_q[i + (1 << s)];
      end else begin : g_pass
        assign stage_v[s][i] = v_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StLoad;
      cnt_q       <= '0;
      stage_q     <= '0;
      v_q         <= '0;
      cw_q        <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      unique case (state_q)
        StLoad: begin
          if (in_valid) begin
            v_q[pos_tbl[cnt_q]] <= in_bit;
            if (cnt_q == CntW'(K - 1)) begin
              state_q    <= StEncode;
              stage_q    <= '0;
              cnt_q      <= '0;
              in_ready_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        StEncode: begin
          v_q <= stage_v[stage_q];
          if (stage_q == StgW'(LOG2N - 1)) begin
            state_q     <= StOut;
            cw_q        <= stage_v[stage_q];
            out_valid_q <= 1'b1;
          end else begin
            stage_q <= stage_q + 1'b1;
          end
        end
        StOut: begin
          // cw_q is left untouched so the codeword persists past the handshake.
          if (out_ready) begin
            state_q     <= StLoad;
            cnt_q       <= '0;
            v_q         <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_codeword = cw_q;
  assign busy         = (state_q != StLoad) || (cnt_q != '0);

endmodule

// File: tb/tb_polar_encoder.sv
// Randomized self-checking bench for polar_encoder against a subset-XOR reference model.
module tb_polar_encoder;

  localparam int unsigned N     = 16;
  localparam int unsigned LOG2N = 4;
  localparam int unsigned K     = 8;
  localparam logic [N-1:0] MASK = 16'h017F;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_bit = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic [N-1:0] out_codeword;
  logic         out_ready = 1'b0;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  polar_encoder #(
    .N           (N),
    .LOG2N       (LOG2N),
    .K           (K),
    .FROZEN_MASK (MASK)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_bit       (in_bit),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_codeword (out_codeword),
    .out_ready    (out_ready),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // u from info bits in ascending non-frozen order; x_j = XOR of u_i over all i containing j.
  function automatic logic [N-1:0] model(input logic [K-1:0] info);
    logic [N-1:0] u;
    logic [N-1:0] x;
    int k;
    u = '0;
    x = '0;
    k = 0;
    for (int i = 0; i < N; i++) begin
      if (!MASK[i]) begin
        u[i] = info[k];
        k++;
      end
    end
    for (int j = 0; j < N; j++)
      for (int i = 0; i < N; i++)
        if ((i & j) == j) x[j] = x[j] ^ u[i];
    return x;
  endfunction

  task automatic send_bits(input logic [K-1:0] info, input int n, input int gap_max);
    int gaps;
    for (int k = 0; k < n; k++) begin
      gaps = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      repeat (gaps) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_bit   = 1'($urandom);
        @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_bit   = info[k];
      check("in_ready_load", 32'(in_ready), 32'd1);
      @(posedge clk);
    end
  endtask

  task automatic recv_check(input logic [N-1:0] exp, input int stall, input bit hold,
                            input bit chk_lat);
    int lat;
    bit seen;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      in_valid = hold;
      in_bit   = 1'($urandom);
      if (lat == 1) begin
        check("busy_encode", 32'(busy), 32'd1);
        check("in_ready_encode", 32'(in_ready), 32'd0);
      end
      seen = out_valid;
    end
    if (!seen) begin
      check("out_valid_timeout", 32'(seen), 32'd1);
      return;
    end
    if (chk_lat) check("latency", 32'(lat), 32'(LOG2N + 1));
    check("codeword", 32'(out_codeword), 32'(exp));
    out_ready = (stall == 0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      in_valid = hold;
      in_bit   = 1'($urandom);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_codeword", 32'(out_codeword), 32'(exp));
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("post_hs_valid", 32'(out_valid), 32'd0);
    check("post_hs_in_ready", 32'(in_ready), 32'd1);
    check("post_hs_busy", 32'(busy), 32'd0);
  endtask

  task automatic reset_check(input string tag);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_codeword"}, 32'(out_codeword), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [K-1:0] info;
    repeat (3) @(posedge clk);
    reset_check("reset");

    out_ready = 1'b1;
    send_bits(8'h01, K, 0);
    recv_check(16'h00FF, 0, 1'b0, 1'b1);
    send_bits(8'h80, K, 0);
    recv_check(16'hFFFF, 0, 1'b0, 1'b1);
    send_bits(8'h02, K, 0);
    recv_check(16'h0303, 0, 1'b0, 1'b1);
    send_bits(8'h81, K, 0);
    recv_check(16'hFF00, 0, 1'b0, 1'b1);

    // Long backpressure in OUT.
    out_ready = 1'b0;
    send_bits(8'h01, K, 0);
    recv_check(16'h00FF, 20, 1'b0, 1'b1);

    // Gaps during LOAD, in_valid held high through ENCODE/OUT.
    send_bits(8'h80, K, 3);
    recv_check(16'hFFFF, 0, 1'b1, 1'b1);
    send_bits(8'h02, K, 3);
    recv_check(16'h0303, 2, 1'b1, 1'b1);
    send_bits(8'h81, K, 3);
    recv_check(16'hFF00, 0, 1'b0, 1'b1);

    // Reset mid-LOAD and mid-ENCODE discards the partial frame.
    send_bits(8'hFF, 5, 0);
    reset_check("rst_load");
    send_bits(8'h01, K, 0);
    recv_check(16'h00FF, 0, 1'b0, 1'b1);
    send_bits(8'hA5, K, 0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset_check("rst_encode");
    send_bits(8'h01, K, 0);
    recv_check(16'h00FF, 0, 1'b0, 1'b1);

    for (int f = 0; f < 1000; f++) begin
      info      = K'($urandom);
      out_ready = 1'($urandom);
      send_bits(info, K, int'($urandom_range(2, 0)));
      recv_check(model(info), int'($urandom_range(3, 0)), 1'($urandom), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
